// File: rtl/delay_sensor_monitor_pkg.sv
// Shared types and defaults for the delay-line sensor monitor.
// Holds the FSM state encoding and the unsigned absolute-difference helper.
package delay_sensor_monitor_pkg;

  localparam int unsigned DEF_WIN_LOG2 = 8;
  localparam int unsigned DEF_THRESH   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALIB = 2'd1,
    MEAS  = 2'd2
  } state_t;

  // Subtract the smaller from the larger so the result never wraps.
  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/delay_sensor_monitor_sync2.sv
// Two-flop synchronizer for bringing the asynchronous delay-line output
// into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/delay_sensor_monitor.sv
// Counts synchronized delayed_clk 1-samples per window; calibrates a baseline
// and flags measurement windows that stray more than THRESH from it.
module delay_sensor_monitor
  import delay_sensor_monitor_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
  parameter int unsigned CNT_W    = WIN_LOG2 + 1,
  parameter int unsigned THRESH   = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             delayed_clk,
  input  logic             en,
  input  logic             calib_req,
  input  logic             clr_alarm,
  output logic [CNT_W-1:0] sample_count,
  output logic             sample_valid,
  output logic [CNT_W-1:0] baseline,
  output logic             baseline_valid,
  output logic             alarm,
  output logic             alarm_sticky,
  output logic             busy
);

  state_t              state;
  logic                s2;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]    acc;
  logic [CNT_W-1:0]    acc_next;
  logic                calib_pend;
  logic                win_last;
  logic                out_of_range;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (delayed_clk),
    .q     (s2)
  );

  // acc_next on the final cycle is the full window result (0..2^WIN_LOG2).
  always_comb begin
    acc_next     = acc + CNT_W'(s2);
    win_last     = (win_cnt == '1);
    out_of_range = abs_diff(32'(acc_next), 32'(baseline)) > THRESH;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      win_cnt        <= '0;
      acc            <= '0;
      calib_pend     <= 1'b0;
      sample_count   <= '0;
      sample_valid   <= 1'b0;
      baseline       <= '0;
      baseline_valid <= 1'b0;
      alarm          <= 1'b0;
      alarm_sticky   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      alarm        <= 1'b0;
      if (clr_alarm) alarm_sticky <= 1'b0;

      case (state)
        IDLE: begin
          if (calib_req || calib_pend) begin
            state   <= CALIB;
            win_cnt <= '0;
            acc     <= '0;
          end else if (en && baseline_valid) begin
            state   <= MEAS;
            win_cnt <= '0;
            acc     <= '0;
          end
        end

        CALIB: begin
          win_cnt <= win_cnt + WIN_LOG2'(1);
          acc     <= acc_next;
          if (win_last) begin
            baseline       <= acc_next;
            baseline_valid <= 1'b1;
            calib_pend     <= 1'b0;
            state          <= IDLE;
          end
        end

        MEAS: begin
          if (calib_req) calib_pend <= 1'b1;
          win_cnt <= win_cnt + WIN_LOG2'(1);
          acc     <= acc_next;
          // A window that reaches its last cycle always completes, even if en
          // drops on that cycle; only earlier cycles abort on !en.
          if (win_last) begin
            sample_count <= acc_next;
            sample_valid <= 1'b1;
            if (out_of_range) begin
              alarm        <= 1'b1;
              alarm_sticky <= 1'b1;
            end
            if (calib_pend || calib_req) begin
              state   <= CALIB;
              win_cnt <= '0;
              acc     <= '0;
            end else if (en) begin
              win_cnt <= '0;
              acc     <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (!en) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sensor_monitor.sv
// Directed bench for delay_sensor_monitor: calibration, back-to-back windows,
// threshold boundary, sticky alarm priority, abort and mid-window events.
module tb_delay_sensor_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       delayed_clk = 1'b1;
  logic       en = 1'b0;
  logic       calib_req = 1'b0;
  logic       clr_alarm = 1'b0;
  logic [8:0] sample_count;
  logic       sample_valid;
  logic [8:0] baseline;
  logic       baseline_valid;
  logic       alarm;
  logic       alarm_sticky;
  logic       busy;

  int checks = 0;
  int failures = 0;

  delay_sensor_monitor #(.WIN_LOG2(8), .CNT_W(9), .THRESH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .delayed_clk    (delayed_clk),
    .en             (en),
    .calib_req      (calib_req),
    .clr_alarm      (clr_alarm),
    .sample_count   (sample_count),
    .sample_valid   (sample_valid),
    .baseline       (baseline),
    .baseline_valid (baseline_valid),
    .alarm          (alarm),
    .alarm_sticky   (alarm_sticky),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    delayed_clk = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sample_count, sample_valid, baseline, baseline_valid, alarm, alarm_sticky, busy} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got cnt=%0d sv=%b base=%0d bv=%b al=%b st=%b busy=%b, expected all 0",
               sample_count, sample_valid, baseline, baseline_valid, alarm, alarm_sticky, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_calib();
    int n = 0;
    bit sv_seen = 1'b0;
    calib_req = 1'b1;
    tick();
    calib_req = 1'b0;
    while (busy && n < 1000) begin
      n++;
      if (sample_valid) sv_seen = 1'b1;
      tick();
    end
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL calib_busy_len: got %0d cycles, expected 256", n);
    end
    checks++;
    if (baseline !== 9'd256 || baseline_valid !== 1'b1) begin
      failures++;
      $display("FAIL calib_baseline: got base=%0d bv=%b, expected 256/1", baseline, baseline_valid);
    end
    checks++;
    if (sv_seen !== 1'b0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL calib_no_sample_valid: got sample_valid seen=%b, expected 0", sv_seen);
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    bit bad_val = 1'b0;
    delayed_clk = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (sample_valid) begin
        hits.push_back(i);
        if (sample_count !== 9'd256 || alarm !== 1'b0) bad_val = 1'b1;
      end
    end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (hits.size() !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d sample_valid pulses, expected 3", hits.size());
    end else begin
      checks++;
      if (hits[0] !== 257 || hits[1] !== 513 || hits[2] !== 769) begin
        failures++;
        $display("FAIL b2b_spacing: got pulses at %0d,%0d,%0d, expected 257,513,769", hits[0], hits[1], hits[2]);
      end
    end
    checks++;
    if (bad_val !== 1'b0) begin
      failures++;
      $display("FAIL b2b_values: got wrong count or alarm in a window, expected 256 and no alarm");
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop: got busy=%b after en drop, expected 0", busy);
    end
  endtask

  // One measurement window with `zeros` consecutive 0-samples mid-window.
  task automatic run_window(input int unsigned zeros, input bit clr_at_end,
                            output logic [8:0] cnt, output logic al, output logic sv);
    delayed_clk = 1'b1;
    en = 1'b1;
    tick();
    repeat (50) tick();
    delayed_clk = 1'b0;
    repeat (zeros) tick();
    delayed_clk = 1'b1;
    repeat (205 - zeros) tick();
    clr_alarm = clr_at_end;
    tick();
    clr_alarm = 1'b0;
    cnt = sample_count;
    al = alarm;
    sv = sample_valid;
    en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_threshold();
    logic [8:0] cnt;
    logic al, sv;
    run_window(4, 1'b0, cnt, al, sv);
    checks++;
    if (sv !== 1'b1 || cnt !== 9'd252 || al !== 1'b0) begin
      failures++;
      $display("FAIL thresh_eq: got sv=%b cnt=%0d alarm=%b, expected 1/252/0", sv, cnt, al);
    end
    checks++;
    if (alarm_sticky !== 1'b0) begin
      failures++;
      $display("FAIL thresh_eq_sticky: got %b, expected 0", alarm_sticky);
    end
    run_window(5, 1'b0, cnt, al, sv);
    checks++;
    if (sv !== 1'b1 || cnt !== 9'd251 || al !== 1'b1) begin
      failures++;
      $display("FAIL thresh_over: got sv=%b cnt=%0d alarm=%b, expected 1/251/1", sv, cnt, al);
    end
    checks++;
    if (alarm_sticky !== 1'b1) begin
      failures++;
      $display("FAIL thresh_over_sticky: got %b, expected 1", alarm_sticky);
    end
  endtask

  task automatic test_clr_collision();
    logic [8:0] cnt;
    logic al, sv;
    run_window(5, 1'b1, cnt, al, sv);
    checks++;
    if (al !== 1'b1 || alarm_sticky !== 1'b1) begin
      failures++;
      $display("FAIL clr_collision: got alarm=%b sticky=%b, expected 1/1", al, alarm_sticky);
    end
    clr_alarm = 1'b1;
    tick();
    clr_alarm = 1'b0;
    checks++;
    if (alarm_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clr_alone: got sticky=%b, expected 0", alarm_sticky);
    end
  endtask

  task automatic test_en_abort();
    bit sv_seen = 1'b0;
    delayed_clk = 1'b1;
    en = 1'b1;
    repeat (101) tick();
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b, expected 0", busy);
    end
    repeat (300) begin
      if (sample_valid || busy) sv_seen = 1'b1;
      tick();
    end
    checks++;
    if (sv_seen !== 1'b0 || sample_count !== 9'd251) begin
      failures++;
      $display("FAIL abort_no_sample: got activity=%b cnt=%0d, expected 0/251", sv_seen, sample_count);
    end
  endtask

  task automatic test_calib_mid_meas();
    int n = 0;
    delayed_clk = 1'b1;
    en = 1'b1;
    repeat (51) tick();
    calib_req = 1'b1;
    tick();
    calib_req = 1'b0;
    repeat (205) tick();
    checks++;
    if (sample_valid !== 1'b1 || sample_count !== 9'd256 || alarm !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL calib_mid_window_end: got sv=%b cnt=%0d al=%b busy=%b, expected 1/256/0/1",
               sample_valid, sample_count, alarm, busy);
    end
    en = 1'b0;
    repeat (20) tick();
    delayed_clk = 1'b0;
    repeat (10) tick();
    delayed_clk = 1'b1;
    while (busy && n < 600) begin
      n++;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || baseline !== 9'd246 || baseline_valid !== 1'b1) begin
      failures++;
      $display("FAIL calib_mid_baseline: got busy=%b base=%0d bv=%b, expected 0/246/1", busy, baseline, baseline_valid);
    end
  endtask

  task automatic test_reset_mid_and_no_baseline();
    bit act = 1'b0;
    calib_req = 1'b1;
    tick();
    calib_req = 1'b0;
    repeat (30) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sample_count, sample_valid, baseline, baseline_valid, alarm, alarm_sticky, busy} !== 23'd0) begin
      failures++;
      $display("FAIL reset_mid: got cnt=%0d sv=%b base=%0d bv=%b al=%b st=%b busy=%b, expected all 0",
               sample_count, sample_valid, baseline, baseline_valid, alarm, alarm_sticky, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (20) begin
      tick();
      if (busy || sample_valid) act = 1'b1;
    end
    en = 1'b0;
    checks++;
    if (act !== 1'b0 || baseline_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_baseline_idle: got activity=%b bv=%b, expected 0/0", act, baseline_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_calib();
    test_back_to_back();
    test_threshold();
    test_clr_collision();
    test_en_abort();
    test_calib_mid_meas();
    test_reset_mid_and_no_baseline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_sensor_monitor.md
Name: delay_sensor_monitor

Overview:
Downstream consumer of the inverter delay-line sensor's delayed_clk output. Samples delayed_clk on every rising edge of clk and counts the 1-samples over a fixed window. The count reflects how the delay line's delay, which tracks voltage and temperature, relates to the clock period. Supports a calibration window that stores a baseline, followed by continuous measurement windows that raise an alarm when a window count deviates from the baseline by more than a threshold (glitch/tamper detection).

Parameters:
WIN_LOG2, 8, window length = 2^WIN_LOG2 clk cycles
CNT_W, WIN_LOG2+1, count width; must hold the value 2^WIN_LOG2
THRESH, 4, maximum allowed |count - baseline| without alarm

Ports:
clk  input  1  system clock (single clock domain)
rst_n  input  1  asynchronous active-low reset
delayed_clk  input  1  delay-line output; asynchronous relative to the sampling flops
en  input  1  level; enables continuous measurement windows
calib_req  input  1  one-cycle pulse; requests a calibration window
clr_alarm  input  1  one-cycle pulse; clears alarm_sticky
sample_count  output  CNT_W  count from the last completed measurement window
sample_valid  output  1  one-cycle pulse when sample_count updates
baseline  output  CNT_W  stored calibration count
baseline_valid  output  1  high once a calibration window has completed
alarm  output  1  one-cycle pulse on an out-of-range window
alarm_sticky  output  1  latched alarm
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE; sync flops, win_cnt, acc, calib_pend, sample_count, baseline all 0; sample_valid, baseline_valid, alarm, alarm_sticky all 0.
- Input sync: delayed_clk passes through a 2-flop synchronizer; s2 is the sample bit. The synchronizer runs in all states, so its latency is 2 cycles.
- States: IDLE, CALIB, MEAS.
- IDLE transitions:
  - calib_req or calib_pend -> CALIB. Calibration has priority over measurement.
  - else en && baseline_valid -> MEAS.
  - en without baseline_valid stays in IDLE.
- Window mechanics:
  - On entry to CALIB/MEAS: win_cnt=0, acc=0.
  - Each cycle in CALIB/MEAS: acc += s2; win_cnt += 1.
  - The final cycle is win_cnt == 2^WIN_LOG2-1. The result is acc + s2 of that cycle, giving a range of 0..2^WIN_LOG2 with no overflow at CNT_W.
- CALIB end: baseline <= result; baseline_valid <= 1; calib_pend <= 0; go to IDLE. No sample_valid and no alarm.
- MEAS end:
  - sample_count <= result; sample_valid = 1 for the next cycle.
  - If |result - baseline| > THRESH, computed unsigned with no wrap: alarm = 1 for that same cycle and alarm_sticky <= 1.
  - Next state: calib_pend -> CALIB. Else en -> a new MEAS window starting the next cycle, with no gap cycle. Else IDLE.
- calib_req during MEAS: sets calib_pend; the current window still completes. calib_req during CALIB: ignored.
- en deasserted mid-MEAS: abort the window and go to IDLE on the next cycle. No sample_valid, no alarm; sample_count is unchanged. en has no effect during CALIB.
- Boundary cases:
  - |diff| == THRESH gives no alarm.
  - clr_alarm in the same cycle as a new alarm: alarm_sticky stays 1 (set wins).
  - calib_req in the same cycle as a MEAS window end: go to CALIB.
- Reset mid-window: everything returns to reset values, including baseline and baseline_valid. Recalibration is required.
- Exactness: counts are exact only for input levels that are stable at s2. Benches hold a constant delayed_clk for at least 2 cycles before window entry.

Decomposition:
- Package delay_sensor_monitor_pkg holds:
  - the state enum (IDLE, CALIB, MEAS);
  - default WIN_LOG2 and THRESH constants;
  - a helper function for the absolute difference.
- Sub-module sync2: a 2-flop synchronizer with asynchronous active-low reset, instantiated once on delayed_clk.
- FSM, counters and compare stay in the top module.

Test Plan:
- Reset, hold delayed_clk=1, calib_req pulse. Expected: busy for 256 cycles, then baseline=256, baseline_valid=1, no sample_valid.
- After baseline=256, delayed_clk=1, en=1. Expected: sample_valid every 256 cycles, back to back, with sample_count=256 and alarm=0.
- Baseline=256, then drive a pattern giving 252 ones. Expected: no alarm (diff 4). Pattern giving 251 ones: alarm pulse, alarm_sticky=1.
- alarm_sticky=1, then clr_alarm pulsed in the same cycle as the next alarm. Expected: sticky stays 1. clr_alarm alone later: sticky=0.
- en dropped at win_cnt=100. Expected: IDLE next cycle, no sample_valid, sample_count unchanged. en=1 with baseline_valid=0: stays IDLE, busy=0.
- Two mid-window cases:
  - calib_req at win_cnt=50 in MEAS: the window completes with sample_valid, then CALIB runs and baseline updates.
  - rst_n low mid-window: all outputs 0 and baseline_valid=0.
